// File: rtl/ltc1666_write_arbiter.sv
// Round-robin arbiter/sequencer sharing one LTC1666 parallel DAC write path among N_REQ requesters.
// Define DAC_ARB_HOLDOFF_EN to add a HOLDOFF_CYCLES idle gap after every acknowledged write.
module ltc1666_write_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [16*N_REQ-1:0]      req_data,
  output logic [N_REQ-1:0]         ack,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     arb_busy,
  output logic                     fault,
  output logic                     start,
  output logic [15:0]              dac_data,
  input  logic                     dac_busy
);

  localparam int GID_W = $clog2(N_REQ);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

`ifdef DAC_ARB_HOLDOFF_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLDOFF} state_t;
  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF_CYCLES - 1);
  logic [15:0] hold_cnt, hold_cnt_d;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
`endif

  state_t           state, state_d;
  logic [15:0]      to_cnt, to_cnt_d;
  logic [GID_W-1:0] last_grant, last_grant_d;
  logic [GID_W-1:0] grant_id_d;
  logic [15:0]      dac_data_d;
  logic [N_REQ-1:0] ack_d;
  logic             start_d, fault_d, arb_busy_d, done;

  logic             sel_found;
  logic [GID_W-1:0] sel_id, cand;
  logic [15:0]      sel_word;

  // Round-robin pick: first set request searching upward from last_grant+1, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    sel_word  = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = GID_W'((int'(last_grant) + k) % N_REQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
        sel_word  = req_data[{cand, 4'b0000} +: 16];
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state;
    to_cnt_d     = to_cnt;
    last_grant_d = last_grant;
    grant_id_d   = grant_id;
    dac_data_d   = dac_data;
    start_d      = 1'b0;
    ack_d        = '0;
    fault_d      = fault;
    done         = 1'b0;
`ifdef DAC_ARB_HOLDOFF_EN
    hold_cnt_d   = hold_cnt;
`endif

    case (state)
      IDLE: begin
        if (sel_found) begin
          grant_id_d = sel_id;
          dac_data_d = sel_word;
          start_d    = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        to_cnt_d = '0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (dac_busy) begin
          to_cnt_d = '0;
          state_d  = WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          fault_d = 1'b1;
          done    = 1'b1;
        end else begin
          to_cnt_d = to_cnt + 16'd1;
        end
      end
      WAIT_DONE: begin
        if (!dac_busy) begin
          done = 1'b1;
        end else if (to_cnt == TO_LAST) begin
          // A stuck interface still completes the write so the requester never hangs.
          fault_d = 1'b1;
          done    = 1'b1;
        end else begin
          to_cnt_d = to_cnt + 16'd1;
        end
      end
`ifdef DAC_ARB_HOLDOFF_EN
      HOLDOFF: begin
        if (hold_cnt == HOLD_LAST) state_d = IDLE;
        else                       hold_cnt_d = hold_cnt + 16'd1;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (done) begin
      ack_d[grant_id] = 1'b1;
      last_grant_d    = grant_id;
      to_cnt_d        = '0;
`ifdef DAC_ARB_HOLDOFF_EN
      if (HOLDOFF_CYCLES > 0) begin
        state_d    = HOLDOFF;
        hold_cnt_d = '0;
      end else begin
        state_d = IDLE;
      end
`else
      state_d = IDLE;
`endif
    end

    // Busy also covers the ack cycle, where the FSM is already back in IDLE.
    arb_busy_d = (state_d != IDLE) || done;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      to_cnt     <= '0;
      last_grant <= GID_W'(N_REQ - 1);
      grant_id   <= '0;
      dac_data   <= '0;
      start      <= 1'b0;
      ack        <= '0;
      fault      <= 1'b0;
      arb_busy   <= 1'b0;
`ifdef DAC_ARB_HOLDOFF_EN
      hold_cnt   <= '0;
`endif
    end else begin
      state      <= state_d;
      to_cnt     <= to_cnt_d;
      last_grant <= last_grant_d;
      grant_id   <= grant_id_d;
      dac_data   <= dac_data_d;
      start      <= start_d;
      ack        <= ack_d;
      fault      <= fault_d;
      arb_busy   <= arb_busy_d;
`ifdef DAC_ARB_HOLDOFF_EN
      hold_cnt   <= hold_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ltc1666_write_arbiter.sv
// Self-checking bench for ltc1666_write_arbiter: transaction-level timing model plus directed scenarios.
// A second instance with TIMEOUT_CYCLES=8 and dac_busy tied low exercises the timeout path.
module tb_ltc1666_write_arbiter;

  localparam int N        = 4;
  localparam int BUSY_LEN = 12;  // DAC interface with SETTLE_CYCLES=10 holds busy for 12 cycles
`ifdef DAC_ARB_HOLDOFF_EN
  localparam int HOLD = 16;
`else
  localparam int HOLD = 0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [16*N-1:0] req_data;
  logic [N-1:0]    ack;
  logic [1:0]      grant_id;
  logic            arb_busy, fault, start, dac_busy;
  logic [15:0]     dac_data;

  logic [N-1:0]    req_to, ack_to;
  logic [1:0]      grant_id_to;
  logic            arb_busy_to, fault_to, start_to, dac_busy_to;
  logic [15:0]     dac_data_to;

  always #5 clk = ~clk;

  ltc1666_write_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(255), .HOLDOFF_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .grant_id(grant_id), .arb_busy(arb_busy), .fault(fault), .start(start),
    .dac_data(dac_data), .dac_busy(dac_busy)
  );

  ltc1666_write_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(8), .HOLDOFF_CYCLES(16)) dut_to (
    .clk(clk), .reset(reset), .req(req_to), .req_data(req_data), .ack(ack_to),
    .grant_id(grant_id_to), .arb_busy(arb_busy_to), .fault(fault_to), .start(start_to),
    .dac_data(dac_data_to), .dac_busy(dac_busy_to)
  );

  // Downstream DAC interface: busy rises the cycle after start and stays high BUSY_LEN cycles.
  int busy_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             busy_cnt <= 0;
    else if (start)        busy_cnt <= BUSY_LEN;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign dac_busy    = (busy_cnt > 0);
  assign dac_busy_to = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: a grant decided in cycle n starts in n+1, acks BUSY_LEN+2 later.
  int          cyc, start_cyc, ack_cyc, busy_end, idle_at, last_g, exp_gid;
  logic [15:0] exp_data;
  int          start_log[$], gid_log[$], ack_log[$];

  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction

  task automatic model_reset();
    cyc = 0; last_g = N - 1; exp_gid = 0; exp_data = 16'h0000;
    start_cyc = -100; ack_cyc = -100; busy_end = -100; idle_at = 0;
    start_log.delete(); gid_log.delete(); ack_log.delete();
  endtask

  task automatic step(input logic [N-1:0] r, input logic [16*N-1:0] d);
    int w;
    @(negedge clk);
    cyc++;
    check("start", 64'(start), 64'(cyc == start_cyc));
    check("ack", 64'(ack), (cyc == ack_cyc) ? 64'(1) << exp_gid : 64'(0));
    check("arb_busy", 64'(arb_busy), 64'(cyc >= start_cyc && cyc <= busy_end));
    check("grant_id", 64'(grant_id), 64'(exp_gid));
    check("dac_data", 64'(dac_data), 64'(exp_data));
    check("fault", 64'(fault), 64'(0));
    if (start) begin start_log.push_back(cyc); gid_log.push_back(int'(grant_id)); end
    if (ack != '0) ack_log.push_back(cyc);
    req = r;
    req_data = d;
    if (cyc >= idle_at && r != '0) begin
      w         = rr_pick(last_g, r);
      exp_gid   = w;
      exp_data  = d[16*w +: 16];
      last_g    = w;
      start_cyc = cyc + 1;
      ack_cyc   = start_cyc + BUSY_LEN + 2;
      busy_end  = ack_cyc + ((HOLD > 0) ? HOLD - 1 : 0);
      idle_at   = ack_cyc + HOLD;
    end
  endtask

  task automatic do_reset(input int hold_cycles);
    reset = 1'b1; req = '0; req_to = '0;
    #1;
    check("rst_start", 64'(start), 64'(0));
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_arb_busy", 64'(arb_busy), 64'(0));
    check("rst_fault", 64'(fault), 64'(0));
    check("rst_grant_id", 64'(grant_id), 64'(0));
    check("rst_dac_data", 64'(dac_data), 64'(0));
    check("rst_fault_to", 64'(fault_to), 64'(0));
    repeat (hold_cycles) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [16*N-1:0] rand_data();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    int acks_seen, got_at;
    logic [N-1:0] r;

    reset = 1'b0; req = '0; req_to = '0; req_data = '0;
    #2;
    do_reset(2);

    // Single request with word 16'h1234
    step(4'b0001, {48'h0, 16'h1234});
    repeat (20) step(4'b0000, rand_data());
    check("single_starts", 64'(start_log.size()), 64'(1));
    check("single_acks", 64'(ack_log.size()), 64'(1));
    if (start_log.size() > 0) check("single_start_cyc", 64'(start_log[0]), 64'(2));
    if (ack_log.size() > 0) check("single_ack_cyc", 64'(ack_log[0]), 64'(16));

    // Round-robin fairness with all requests held
    do_reset(2);
    repeat (5 * (BUSY_LEN + 3 + HOLD) + 4) step(4'b1111, rand_data());
    check("rr_count_ge5", 64'(gid_log.size() >= 5), 64'(1));
    for (int i = 0; i < 5; i++)
      if (i < gid_log.size()) check($sformatf("rr_gid%0d", i), 64'(gid_log[i]), 64'(rr_exp[i]));

    // Requester 1 drops req and changes its word right after grant
    do_reset(2);
    step(4'b0010, {32'h0, 16'hABCD, 16'h0});
    step(4'b0000, '0);
    repeat (20 + HOLD) step(4'b0000, '0);
    check("chg_acks", 64'(ack_log.size()), 64'(1));
    if (gid_log.size() > 0) check("chg_gid", 64'(gid_log[0]), 64'(1));
    check("chg_data_held", 64'(dac_data), 64'(16'hABCD));

    // Spacing between the first ack and the next start with req0 held
    do_reset(2);
    repeat (2 * (BUSY_LEN + 3 + HOLD) + 6) step(4'b0001, rand_data());
    if (start_log.size() > 1 && ack_log.size() > 0)
      check("hold_gap", 64'(start_log[1] - ack_log[0]), 64'(HOLD + 1));
    else
      check("hold_two_starts", 64'(0), 64'(1));

    // Timeout: dac_busy stuck low on the second instance
    do_reset(2);
    step(4'b0000, rand_data());
    req_to = 4'b0001;
    acks_seen = 0; got_at = -1;
    for (int i = 0; i < 60; i++) begin
      step(4'b0000, rand_data());
      if (i == 0) check("to_fault_before", 64'(fault_to), 64'(0));
      if (i == 3) req_to = '0;
      if (ack_to != '0) begin
        acks_seen++;
        if (got_at < 0) begin
          got_at = i;
          check("to_ack_bits", 64'(ack_to), 64'(4'b0001));
          check("to_fault_at_ack", 64'(fault_to), 64'(1));
        end
      end
    end
    check("to_ack_seen", 64'(got_at >= 0), 64'(1));
    check("to_ack_time", 64'(got_at >= 9 && got_at <= 10), 64'(1));
    check("to_ack_once", 64'(acks_seen), 64'(1));
    check("to_back_idle", 64'(arb_busy_to), 64'(0));
    check("to_fault_sticky", 64'(fault_to), 64'(1));

    // Async reset in WAIT_DONE, between clock edges; first grant afterwards is requester 0
    do_reset(2);
    step(4'b0100, rand_data());
    repeat (7) step(4'b0100, rand_data());
    check("mid_in_wait_done", 64'(dac_busy && arb_busy), 64'(1));
    do_reset(3);
    repeat (BUSY_LEN + 6 + HOLD) step(4'b1111, rand_data());
    if (gid_log.size() > 0) check("post_rst_gid", 64'(gid_log[0]), 64'(0));
    else check("post_rst_grant", 64'(0), 64'(1));

    // Randomized traffic against the reference timing model
    do_reset(2);
    r = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      step(r, rand_data());
    end
    check("rand_progress", 64'(ack_log.size() > 20), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
